oreg_uart_tx: RTL and testbench

//  Output-port streamer placed directly downstream of the microprocessor's output register.

---
 rtl/oreg_uart_tx_pkg.sv | 27 ++
 rtl/oreg_uart_tx_nibble_fifo.sv | 71 +++++++
 rtl/oreg_uart_tx.sv | 132 +++++++++++++
 tb/tb_oreg_uart_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/oreg_uart_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : oreg_uart_tx_pkg                                       |
// | Description : Shared UART FSM state codes and nibble-to-ASCII helper |
// |               for the output-register debug streamer.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package oreg_uart_tx_pkg;

  // UART transmitter states
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  // Map a nibble to its upper-case ASCII hex digit.
  // 'A' is 8'h41, so digits A-F are 8'h41 + (n - 10) = 8'h37 + n.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else begin
      return 8'h37 + {4'h0, n};
    end
  endfunction

endpackage : oreg_uart_tx_pkg
`default_nettype wire

// File: rtl/oreg_uart_tx_nibble_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : oreg_uart_tx_nibble_fifo                               |
// | Description : DEPTH x 4-bit FIFO with first-word fall-through head.  |
// |               Push at full is accepted only when a pop frees a slot  |
// |               on the same edge.                                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module oreg_uart_tx_nibble_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [3:0]               din,
  output logic [3:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW-1:0] c_PTR_LAST = c_AW'(DEPTH - 1);
  localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(DEPTH);

  logic [3:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            w_pop;
  logic            w_push;

  assign full   = (r_count == c_FULL_CNT);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_pop  = pop && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign w_push = push && (!full || w_pop);

  // Storage array; contents are unobservable after reset because the pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers reload to zero explicitly at the last slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : oreg_uart_tx_nibble_fifo
`default_nettype wire

// File: rtl/oreg_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : oreg_uart_tx                                           |
// | Description : Captures output-register nibble writes into a FIFO and |
// |               streams each one as an ASCII hex char on 8N1 UART.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module oreg_uart_tx
  import oreg_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   data_bus,
  input  logic                         o_reg_wr,
  input  logic                         tx_en,
  input  logic                         ovf_clr,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_overflow;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [3:0]  w_head;
  logic        w_bit_done;

  oreg_uart_tx_nibble_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (o_reg_wr),
    .pop   (w_pop),
    .din   (data_bus),
    .dout  (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_pop      = (r_state == c_ST_IDLE) && tx_en && !w_empty;
  assign w_bit_done = (r_baud == c_BAUD_LAST);
  assign tx         = r_tx;
  assign busy       = (r_state != c_ST_IDLE);
  assign overflow   = r_overflow;

  // Frame sequencer: the next line level is registered so tx never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= nibble_to_ascii(w_head);
            r_tx    <= 1'b0;
            r_state <= c_ST_START;
          end
        end
        c_ST_START: begin
          if (w_bit_done) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= c_ST_DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        c_ST_DATA: begin
          if (w_bit_done) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= c_ST_STOP;
            end else begin
              // Shift first so the next LSB is always at bit 1 of the current value.
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        c_ST_STOP: begin
          if (w_bit_done) begin
            r_baud  <= '0;
            r_state <= c_ST_IDLE;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow: a dropped push sets it and outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (o_reg_wr && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

endmodule : oreg_uart_tx
`default_nettype wire

// File: tb/tb_oreg_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_oreg_uart_tx                                        |
// | Description : Self-checking bench for oreg_uart_tx: directed table,  |
// |               hand-written corner sequences and random traffic vs a  |
// |               queue-based line model.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_oreg_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_bus = 4'h0;
  logic       o_reg_wr = 1'b0;
  logic       tx_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  oreg_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_bus   (data_bus),
    .o_reg_wr   (o_reg_wr),
    .tx_en      (tx_en),
    .ovf_clr    (ovf_clr),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Reference model: queue of pending nibbles plus a frame timer.
  logic [3:0] mq[$];
  bit         m_active;
  int         m_t;
  logic [9:0] m_frame;
  bit         m_ovf;

  function automatic logic [7:0] ref_ascii(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  function automatic logic exp_tx();
    return m_active ? m_frame[m_t / CPB] : 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active = 0;
    m_t      = 0;
    m_frame  = '1;
    m_ovf    = 0;
  endtask

  task automatic model_step(input logic p, input logic [3:0] d, input logic en, input logic c);
    bit pop, full, set;
    pop  = !m_active && en && (mq.size() != 0);
    full = (mq.size() == DEPTH);
    set  = p && full && !pop;
    if (m_active) begin
      m_t++;
      if (m_t == 10 * CPB) m_active = 0;
    end
    if (pop) begin
      m_frame  = {1'b1, ref_ascii(int'(mq.pop_front())), 1'b0};
      m_active = 1;
      m_t      = 0;
    end
    if (p && (!full || pop)) mq.push_back(d);
    if (set) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with given inputs; every output is compared with the model afterwards.
  task automatic cycle(input logic p, input logic [3:0] d, input logic en, input logic c);
    o_reg_wr = p;
    data_bus = d;
    tx_en    = en;
    ovf_clr  = c;
    @(posedge clk);
    model_step(p, d, en, c);
    #1;
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("busy", 32'(busy), 32'(m_active));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, en, 1'b0);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic async_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_tx"}, 32'(tx), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       p;
    logic [3:0] d;
    logic       en;
    logic       c;
    int         e_cnt;
    logic       e_ovf;
  } vec_t;

  initial begin
    vec_t       tbl[9];
    logic [9:0] f1;
    model_reset();

    // Reset state
    #1;
    async_reset("reset");

    // Test 1: single 'A' -> 8'h41 frame, 4 clk per bit
    f1 = {1'b1, 8'h41, 1'b0};
    cycle(1'b1, 4'hA, 1'b1, 1'b0);
    for (int k = 0; k < 10 * CPB; k++) begin
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      chk("t1_frame_bit", 32'(tx), 32'(f1[k / CPB]));
      chk("t1_busy", 32'(busy), 32'd1);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Test 2: back-to-back frames 3,7,F
    cycle(1'b1, 4'h3, 1'b1, 1'b0);
    cycle(1'b1, 4'h7, 1'b1, 1'b0);
    cycle(1'b1, 4'hF, 1'b1, 1'b0);
    idle(3 * (10 * CPB + 1) + 4, 1'b1);
    chk("t2_count_end", 32'(fifo_count), 32'd0);

    // Test 3: overflow table with tx_en low
    tbl[0] = '{1'b1, 4'h1, 1'b0, 1'b0, 1, 1'b0};
    tbl[1] = '{1'b1, 4'h2, 1'b0, 1'b0, 2, 1'b0};
    tbl[2] = '{1'b1, 4'h3, 1'b0, 1'b0, 3, 1'b0};
    tbl[3] = '{1'b1, 4'h4, 1'b0, 1'b0, 4, 1'b0};
    tbl[4] = '{1'b1, 4'h5, 1'b0, 1'b0, 4, 1'b1};
    tbl[5] = '{1'b0, 4'h0, 1'b0, 1'b1, 4, 1'b0};
    tbl[6] = '{1'b1, 4'h6, 1'b0, 1'b1, 4, 1'b1};
    tbl[7] = '{1'b0, 4'h0, 1'b0, 1'b1, 4, 1'b0};
    tbl[8] = '{1'b0, 4'h0, 1'b0, 1'b0, 4, 1'b0};
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].p, tbl[i].d, tbl[i].en, tbl[i].c);
      chk($sformatf("t3_row%0d_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      chk($sformatf("t3_row%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
    end
    idle(4 * (10 * CPB + 1) + 4, 1'b1);
    chk("t3_drained", 32'(fifo_count), 32'd0);

    // Test 4: push and pop on the same edge at full
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 4'(i + 8), 1'b0, 1'b0);
    cycle(1'b1, 4'h9, 1'b1, 1'b0);
    chk("t4_count", 32'(fifo_count), 32'd4);
    chk("t4_ovf", 32'(overflow), 32'd0);
    idle(5 * (10 * CPB + 1) + 4, 1'b1);

    // Test 5: reset during DATA bit 3
    cycle(1'b1, 4'hC, 1'b1, 1'b0);
    cycle(1'b1, 4'hD, 1'b1, 1'b0);
    idle(17, 1'b1);
    async_reset("t5");
    idle(60, 1'b1);
    chk("t5_line_idle", 32'(tx), 32'd1);

    // Test 6: drop tx_en mid-frame with two entries queued
    cycle(1'b1, 4'h1, 1'b1, 1'b0);
    cycle(1'b1, 4'h2, 1'b1, 1'b0);
    cycle(1'b1, 4'h3, 1'b1, 1'b0);
    idle(60, 1'b0);
    chk("t6_count_held", 32'(fifo_count), 32'd2);
    chk("t6_tx_high", 32'(tx), 32'd1);
    idle(2 * (10 * CPB + 1) + 4, 1'b1);
    chk("t6_drained", 32'(fifo_count), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        async_reset("rnd_reset");
      end else begin
        cycle($urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 9) != 0,
              $urandom_range(0, 15) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_oreg_uart_tx
`default_nettype wire
